// File: rtl/neuron_config_loader.sv
// Streams per-neuron configuration records (header, weights, bias) into
// registered weight/bias strobes with target layer/neuron, flagging illegal headers.
module neuron_config_loader #(
    parameter int maxWeights = 784,
    parameter int numLayers  = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] s_data,
    input  logic        s_valid,
    output logic        s_ready,
    output logic        weightValid,
    output logic [31:0] weightValue,
    output logic        biasValid,
    output logic [31:0] biasValue,
    output logic [31:0] config_layer_num,
    output logic [31:0] config_neuron_num,
    output logic [15:0] neurons_loaded,
    output logic        load_done,
    output logic        err
);

    typedef enum logic [2:0] {HDR, WGT, BIAS, DROP, DONE} state_t;

    state_t      state, state_nxt;
    logic [16:0] cnt;
    logic        accept;
    logic [7:0]  hdr_layer;
    logic [7:0]  hdr_neuron;
    logic [15:0] hdr_count;
    logic        hdr_empty;
    logic        hdr_bad;
    logic        cnt_last;

    assign hdr_layer  = s_data[31:24];
    assign hdr_neuron = s_data[23:16];
    assign hdr_count  = s_data[15:0];
    assign hdr_empty  = (hdr_count == 16'd0);
    assign hdr_bad    = ({16'd0, hdr_count} > 32'(maxWeights)) ||
                        ({24'd0, hdr_layer} >= 32'(numLayers));
    assign accept     = s_valid && s_ready;
    assign cnt_last   = (cnt == 17'd1);

    always_ff @(posedge clk) begin
        if (rst) state <= HDR;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        s_ready   = (state != DONE);
        load_done = (state == DONE);
        case (state)
            HDR: begin
                if (accept) begin
                    if (hdr_empty)    state_nxt = DONE;
                    else if (hdr_bad) state_nxt = DROP;
                    else              state_nxt = WGT;
                end
            end
            WGT:     if (accept && cnt_last) state_nxt = BIAS;
            BIAS:    if (accept)             state_nxt = HDR;
            DROP:    if (accept && cnt_last) state_nxt = HDR;
            DONE:    state_nxt = HDR;
            default: state_nxt = HDR;
        endcase
    end

    // Strobes are registered, so a word accepted on one edge appears on the next cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            weightValid       <= 1'b0;
            weightValue       <= '0;
            biasValid         <= 1'b0;
            biasValue         <= '0;
            config_layer_num  <= '0;
            config_neuron_num <= '0;
            neurons_loaded    <= '0;
            err               <= 1'b0;
            cnt               <= '0;
        end else begin
            weightValid <= 1'b0;
            biasValid   <= 1'b0;
            if (accept) begin
                case (state)
                    HDR: begin
                        if (!hdr_empty) begin
                            if (hdr_bad) begin
                                err <= 1'b1;
                                cnt <= {1'b0, hdr_count} + 17'd1;
                            end else begin
                                config_layer_num  <= {24'd0, hdr_layer};
                                config_neuron_num <= {24'd0, hdr_neuron};
                                cnt               <= {1'b0, hdr_count};
                            end
                        end
                    end
                    WGT: begin
                        weightValid <= 1'b1;
                        weightValue <= s_data;
                        cnt         <= cnt - 17'd1;
                    end
                    BIAS: begin
                        biasValid      <= 1'b1;
                        biasValue      <= s_data;
                        neurons_loaded <= neurons_loaded + 16'd1;
                    end
                    DROP: cnt <= cnt - 17'd1;
                    default: ;
                endcase
            end
        end
    end

endmodule
